cacheline_mem_responder: RTL and testbench

//  Memory-side responder for the cache's line bus (cache acts as controller, this block as device).

---
 rtl/cache_pkg.sv | 28 ++
 rtl/cacheline_ram.sv | 45 ++++
 rtl/cacheline_mem_responder.sv | 176 +++++++++++++++++
 tb/tb_cacheline_mem_responder.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// ----------------------------------------------------------------------------
// cache_pkg
// Shared types and constants for the cache line bus responder.
//   S_OFFSET     : byte-offset bits per line (line = 2**S_OFFSET bytes)
//   S_LINE       : line width in bits
//   line_t       : one cache line
//   resp_state_t : responder FSM states
//   lat_cnt_w()  : width of a down-counter that holds (max_lat-1)
// ----------------------------------------------------------------------------
package cache_pkg;

    localparam int S_OFFSET = 5;
    localparam int S_LINE   = 8 * (2 ** S_OFFSET);

    typedef logic [S_LINE-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    // Counter width able to hold max_lat-1; never narrower than one bit.
    function automatic int lat_cnt_w(input int max_lat);
        return (max_lat > 2) ? $clog2(max_lat) : 1;
    endfunction

endpackage

// File: rtl/cacheline_ram.sv
// ----------------------------------------------------------------------------
// cacheline_ram
// Single-port synchronous line RAM with a per-byte write mask. No reset:
// contents survive a responder reset.
// Ports:
//   clk_i    : clock, rising edge
//   we_i     : write strobe (bytes selected by be_i)
//   re_i     : read strobe; rdata_o updates on the following edge
//   addr_i   : line index
//   wdata_i  : write line
//   be_i     : byte write mask, bit i -> byte i
//   rdata_o  : registered read line
// ----------------------------------------------------------------------------
module cacheline_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 256
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic                re_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] be_i,
    output logic [DATA_W-1:0]   rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cacheline_mem_responder.sv
// ----------------------------------------------------------------------------
// cacheline_mem_responder
// Memory-side device on the cache line bus. Accepts a line read or write,
// waits a programmable latency, then completes with a one-cycle mem_resp.
// Optional feature macro: CACHELINE_MEM_BYTE_EN (adds mem_byte_enable and
// masks writes per byte; otherwise every write replaces the whole line).
// Ports:
//   CLK, RST_N      : clock (rising edge), asynchronous active-low reset
//   mem_read        : line read request, held until mem_resp
//   mem_write       : line write request, held until mem_resp
//   mem_address     : byte address, low s_offset bits ignored
//   mem_wdata       : write line
//   mem_byte_enable : per-byte write mask (CACHELINE_MEM_BYTE_EN only)
//   mem_rdata       : last read line, updated with a read's mem_resp
//   mem_resp        : one-cycle completion pulse
//   proto_err       : sticky protocol-violation flag
//   dbg_state_o     : current FSM state (resp_state_t encoding)
// Handshake: a request is accepted on the first edge it is seen in IDLE;
// the cache must hold read/write/address stable until it samples mem_resp,
// after which it drops or changes the request. mem_resp rises LATENCY+1
// edges after the accept edge.
// ----------------------------------------------------------------------------
module cacheline_mem_responder
    import cache_pkg::*;
#(
    parameter int s_offset   = S_OFFSET,
    parameter int s_line     = S_LINE,
    parameter int IDX_BITS   = 8,
    parameter int RD_LATENCY = 4,
    parameter int WR_LATENCY = 4
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [31:0]         mem_address,
    input  logic [s_line-1:0]   mem_wdata,
`ifdef CACHELINE_MEM_BYTE_EN
    input  logic [s_line/8-1:0] mem_byte_enable,
`endif
    output logic [s_line-1:0]   mem_rdata,
    output logic                mem_resp,
    output logic                proto_err,
    output logic [1:0]          dbg_state_o
);

    localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CNT_W   = lat_cnt_w(MAX_LAT);
    localparam int BE_W    = s_line / 8;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LATENCY - 1);

    resp_state_t         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                op_write_q;
    logic [31:0]         addr_q;
    logic [s_line-1:0]   wdata_q;
    logic [s_line-1:0]   rdata_q;
    logic                resp_q;
    logic                err_q;

    logic                accept;
    logic                err_set;
    logic                ram_re;
    logic                ram_we;
    logic [BE_W-1:0]     ram_be;
    logic [s_line-1:0]   ram_rdata;
    logic [IDX_BITS-1:0] ram_addr;

`ifdef CACHELINE_MEM_BYTE_EN
    logic [BE_W-1:0]     be_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            be_q <= '0;
        end else if (accept) begin
            be_q <= mem_byte_enable;
        end
    end

    assign ram_be = be_q;
`else
    assign ram_be = '1;
`endif

    // Upper address bits beyond the index are dropped, so indices wrap.
    assign ram_addr = addr_q[s_offset +: IDX_BITS];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        err_set = 1'b0;
        ram_re  = 1'b0;
        ram_we  = 1'b0;
        case (state_q)
            IDLE: begin
                // While mem_resp is high the cache still holds the request it
                // just got an answer for; it must not be taken a second time.
                if ((mem_read || mem_write) && !resp_q) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                    cnt_d   = mem_write ? WR_LOAD : RD_LOAD;
                    err_set = mem_read && mem_write;
                end
            end
            BUSY: begin
                if (op_write_q ? !mem_write : !mem_read) begin
                    err_set = 1'b1;
                end
                if (mem_address != addr_q) begin
                    err_set = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d = RESP;
                    // Sync RAM: data is ready during the RESP cycle.
                    ram_re  = !op_write_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                ram_we  = op_write_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            resp_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= (state_q == RESP);
            err_q   <= err_q | err_set;
            if (accept) begin
                op_write_q <= mem_write;
                addr_q     <= mem_address;
                wdata_q    <= mem_wdata;
            end
            if (state_q == RESP && !op_write_q) begin
                rdata_q <= ram_rdata;
            end
        end
    end

    cacheline_ram #(
        .ADDR_W (IDX_BITS),
        .DATA_W (s_line)
    ) u_ram (
        .clk_i   (CLK),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (wdata_q),
        .be_i    (ram_be),
        .rdata_o (ram_rdata)
    );

    assign mem_rdata   = rdata_q;
    assign mem_resp    = resp_q;
    assign proto_err   = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cacheline_mem_responder.sv
`timescale 1ns/1ps
module tb_cacheline_mem_responder;

    localparam int RD_LAT = 4;
    localparam int WR_LAT = 4;
    localparam int IDXB   = 8;
`ifdef CACHELINE_MEM_BYTE_EN
    localparam bit BE_ON = 1'b1;
`else
    localparam bit BE_ON = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [31:0]  mem_address = '0;
    logic [255:0] mem_wdata = '0;
    logic [31:0]  mem_byte_enable = '1;
    logic [255:0] mem_rdata;
    logic         mem_resp;
    logic         proto_err;
    logic [1:0]   dbg_state;

    always #5 CLK = ~CLK;

    cacheline_mem_responder #(
        .IDX_BITS   (IDXB),
        .RD_LATENCY (RD_LAT),
        .WR_LATENCY (WR_LAT)
    ) dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
`ifdef CACHELINE_MEM_BYTE_EN
        .mem_byte_enable (mem_byte_enable),
`endif
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .proto_err       (proto_err),
        .dbg_state_o     (dbg_state)
    );

    // ---------------- reference model / scoreboard ----------------
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [255:0] model_mem [256];
    bit           model_valid [256];
    logic [255:0] exp_rdata = '0;
    bit           exp_err = 1'b0;
    logic [255:0] exp_q [$];

    function automatic int idx_of(input logic [31:0] a);
        return int'(a[5 +: IDXB]);
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [255:0] d,
                                        input logic [31:0] be);
        int i;
        i = idx_of(a);
        for (int b = 0; b < 32; b++) begin
            if (!BE_ON || be[b]) model_mem[i][b*8 +: 8] = d[b*8 +: 8];
        end
        model_valid[i] = 1'b1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge CLK);
        RST_N     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N     = 1'b1;
        exp_err   = 1'b0;
        exp_rdata = '0;
    endtask

    // Presents a request and waits (bounded) for mem_resp. lat is the number
    // of edges from the accept edge to mem_resp high, -1 on timeout.
    // At tweak_at cycles after accept the request is dropped or re-addressed.
    task automatic do_op(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] wd, input logic [31:0] be,
                         input int tweak_at, input bit tweak_drop,
                         input logic [31:0] tweak_addr,
                         output logic [255:0] rdat, output int lat);
        @(negedge CLK);
        mem_read        = rd;
        mem_write       = wr;
        mem_address     = addr;
        mem_wdata       = wd;
        mem_byte_enable = be;
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (mem_resp === 1'b1) begin
                lat = c - 1;
                break;
            end
            if (c == tweak_at) begin
                if (tweak_drop) begin
                    mem_read  = 1'b0;
                    mem_write = 1'b0;
                end else begin
                    mem_address = tweak_addr;
                end
            end
        end
        rdat      = mem_rdata;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (mem_resp !== 1'b0) begin
            n_bad++; $display("FAIL reset_resp: got %b want 0", mem_resp);
        end
        n_cmp++;
        if (mem_rdata !== 256'd0) begin
            n_bad++; $display("FAIL reset_rdata: got %h want 0", mem_rdata);
        end
        n_cmp++;
        if (proto_err !== 1'b0) begin
            n_bad++; $display("FAIL reset_err: got %b want 0", proto_err);
        end
    endtask

    task automatic test_write_read();
        logic [255:0] r;
        int lat;
        do_op(1'b0, 1'b1, 32'h40, {32{8'hA5}}, '1, 0, 1'b0, 0, r, lat);
        model_write(32'h40, {32{8'hA5}}, '1);
        n_cmp++;
        if (lat !== WR_LAT + 1) begin
            n_bad++; $display("FAIL write_latency: got %0d want %0d", lat, WR_LAT + 1);
        end
        n_cmp++;
        if (r !== exp_rdata) begin
            n_bad++; $display("FAIL write_keeps_rdata: got %h want %h", r, exp_rdata);
        end
        do_op(1'b1, 1'b0, 32'h40, '0, '1, 0, 1'b0, 0, r, lat);
        exp_rdata = {32{8'hA5}};
        n_cmp++;
        if (lat !== RD_LAT + 1) begin
            n_bad++; $display("FAIL read_latency: got %0d want %0d", lat, RD_LAT + 1);
        end
        n_cmp++;
        if (r !== exp_rdata) begin
            n_bad++; $display("FAIL read_back: got %h want %h", r, exp_rdata);
        end
        // Offset bits must not affect which line is returned.
        do_op(1'b1, 1'b0, 32'h47, '0, '1, 0, 1'b0, 0, r, lat);
        n_cmp++;
        if (r !== {32{8'hA5}}) begin
            n_bad++; $display("FAIL read_offset: got %h want %h", r, {32{8'hA5}});
        end
    endtask

    task automatic test_byte_en();
        logic [255:0] r, want;
        int lat;
        do_op(1'b0, 1'b1, 32'h60, {32{8'hFF}}, '1, 0, 1'b0, 0, r, lat);
        model_write(32'h60, {32{8'hFF}}, '1);
        do_op(1'b0, 1'b1, 32'h60, {32{8'h11}}, 32'h0000_000F, 0, 1'b0, 0, r, lat);
        model_write(32'h60, {32{8'h11}}, 32'h0000_000F);
        want = BE_ON ? {{28{8'hFF}}, {4{8'h11}}} : {32{8'h11}};
        do_op(1'b1, 1'b0, 32'h60, '0, '1, 0, 1'b0, 0, r, lat);
        exp_rdata = model_mem[idx_of(32'h60)];
        n_cmp++;
        if (r !== want) begin
            n_bad++; $display("FAIL byte_enable: got %h want %h", r, want);
        end
    endtask

    task automatic test_reset_mid();
        logic [255:0] r;
        int lat;
        bit saw_resp;
        do_op(1'b0, 1'b1, 32'hC0, {8{32'h1234_5678}}, '1, 0, 1'b0, 0, r, lat);
        model_write(32'hC0, {8{32'h1234_5678}}, '1);
        @(negedge CLK);
        mem_write   = 1'b1;
        mem_address = 32'hC0;
        mem_wdata   = {8{32'hDEAD_BEEF}};
        repeat (2) @(posedge CLK);
        #2 RST_N = 1'b0;
        saw_resp = 1'b0;
        @(negedge CLK);
        mem_write = 1'b0;
        RST_N     = 1'b1;
        exp_err   = 1'b0;
        exp_rdata = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (mem_resp === 1'b1) saw_resp = 1'b1;
        end
        n_cmp++;
        if (saw_resp !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid_resp: got %b want 0", saw_resp);
        end
        do_op(1'b1, 1'b0, 32'hC0, '0, '1, 0, 1'b0, 0, r, lat);
        exp_rdata = model_mem[idx_of(32'hC0)];
        n_cmp++;
        if (r !== exp_rdata) begin
            n_bad++; $display("FAIL reset_mid_ram: got %h want %h", r, exp_rdata);
        end
    endtask

    task automatic test_wrap();
        logic [255:0] r;
        int lat;
        do_op(1'b0, 1'b1, 32'h2000, {16{16'hC3C3}}, '1, 0, 1'b0, 0, r, lat);
        model_write(32'h2000, {16{16'hC3C3}}, '1);
        do_op(1'b1, 1'b0, 32'h0000, '0, '1, 0, 1'b0, 0, r, lat);
        exp_rdata = model_mem[0];
        n_cmp++;
        if (r !== {16{16'hC3C3}}) begin
            n_bad++; $display("FAIL index_wrap: got %h want %h", r, {16{16'hC3C3}});
        end
    endtask

    task automatic test_proto_busy();
        logic [255:0] r;
        int lat;
        do_reset();
        // Drop the write one cycle after accept: it must still complete.
        do_op(1'b0, 1'b1, 32'h100, {8{32'h0F0F_A0A0}}, '1, 1, 1'b1, 0, r, lat);
        model_write(32'h100, {8{32'h0F0F_A0A0}}, '1);
        exp_err = 1'b1;
        n_cmp++;
        if (lat !== WR_LAT + 1) begin
            n_bad++; $display("FAIL drop_latency: got %0d want %0d", lat, WR_LAT + 1);
        end
        n_cmp++;
        if (proto_err !== exp_err) begin
            n_bad++; $display("FAIL drop_err: got %b want %b", proto_err, exp_err);
        end
        do_reset();
        // Re-address a read mid-flight: the latched address wins.
        do_op(1'b1, 1'b0, 32'h100, '0, '1, 2, 1'b0, 32'h120, r, lat);
        exp_rdata = model_mem[idx_of(32'h100)];
        exp_err = 1'b1;
        n_cmp++;
        if (r !== exp_rdata) begin
            n_bad++; $display("FAIL addr_change_data: got %h want %h", r, exp_rdata);
        end
        n_cmp++;
        if (proto_err !== exp_err) begin
            n_bad++; $display("FAIL addr_change_err: got %b want %b", proto_err, exp_err);
        end
    endtask

    task automatic test_both_high();
        logic [255:0] r;
        int lat;
        do_reset();
        do_op(1'b1, 1'b1, 32'h80, {4{64'h0123_4567_89AB_CDEF}}, '1, 0, 1'b0, 0, r, lat);
        model_write(32'h80, {4{64'h0123_4567_89AB_CDEF}}, '1);
        exp_err = 1'b1;
        n_cmp++;
        if (lat !== WR_LAT + 1) begin
            n_bad++; $display("FAIL both_latency: got %0d want %0d", lat, WR_LAT + 1);
        end
        n_cmp++;
        if (r !== exp_rdata) begin
            n_bad++; $display("FAIL both_rdata_kept: got %h want %h", r, exp_rdata);
        end
        do_op(1'b1, 1'b0, 32'h80, '0, '1, 0, 1'b0, 0, r, lat);
        exp_rdata = model_mem[idx_of(32'h80)];
        n_cmp++;
        if (r !== exp_rdata) begin
            n_bad++; $display("FAIL both_write_done: got %h want %h", r, exp_rdata);
        end
        n_cmp++;
        if (proto_err !== exp_err) begin
            n_bad++; $display("FAIL both_err_sticky: got %b want %b", proto_err, exp_err);
        end
    endtask

    task automatic test_random();
        logic [255:0] r, d, want;
        logic [31:0]  addr, be;
        int lat, idx;
        bit wr;
        for (int n = 0; n < 40; n++) begin
            idx  = $urandom_range(0, 15);
            addr = ($urandom & 32'hFFFF_E000) | (32'(idx) << 5) | 32'($urandom_range(0, 31));
            wr   = ($urandom_range(0, 1) == 1) || !model_valid[idx];
            d    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            be   = model_valid[idx] ? $urandom : 32'hFFFF_FFFF;
            if (wr) begin
                do_op(1'b0, 1'b1, addr, d, be, 0, 1'b0, 0, r, lat);
                model_write(addr, d, be);
                want = exp_rdata;
            end else begin
                exp_q.push_back(model_mem[idx]);
                do_op(1'b1, 1'b0, addr, '0, '1, 0, 1'b0, 0, r, lat);
                want = exp_q.pop_front();
                exp_rdata = want;
            end
            n_cmp++;
            if (lat !== (wr ? WR_LAT + 1 : RD_LAT + 1)) begin
                n_bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, lat,
                                  wr ? WR_LAT + 1 : RD_LAT + 1);
            end
            n_cmp++;
            if (r !== want) begin
                n_bad++; $display("FAIL rand_rdata[%0d]: got %h want %h", n, r, want);
            end
        end
        n_cmp++;
        if (proto_err !== exp_err) begin
            n_bad++; $display("FAIL rand_err: got %b want %b", proto_err, exp_err);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_write_read();
        test_byte_en();
        test_reset_mid();
        test_wrap();
        test_proto_busy();
        test_both_high();
        do_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
